// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and instruction geometry
// Purpose: fetch sequencer state type, default lane geometry and the
//          lane-select width helper shared by the fetch register, ALU and decoder.
// Ports:   none (package).
package cpu_pkg;

  localparam int CPU_LANE_WIDTH = 8;
  localparam int CPU_LANES      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  // A single lane still needs a one-bit select so ports never collapse to zero width.
  function automatic int sel_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/ir_lane_bank.sv
// rtl/ir_lane_bank.sv - lane-addressed instruction register storage
// Purpose: LANES registers of LANE_WIDTH bits with one synchronous write port.
// Ports:   clk_i      rising-edge clock
//          rst_i      synchronous active-high reset, clears every lane
//          wr_en_i    write enable
//          wr_lane_i  lane index; indices >= LANES match no lane and are dropped
//          wr_data_i  data written to the addressed lane
//          ir_o       packed lanes, lane k at bits [(k+1)*LANE_WIDTH-1 : k*LANE_WIDTH]
module ir_lane_bank
  import cpu_pkg::*;
#(
  parameter int LANE_WIDTH = CPU_LANE_WIDTH,
  parameter int LANES      = CPU_LANES,
  parameter int SEL_W      = sel_width(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [SEL_W-1:0]            wr_lane_i,
  input  logic [LANE_WIDTH-1:0]       wr_data_i,
  output logic [LANES*LANE_WIDTH-1:0] ir_o
);

  logic [LANE_WIDTH-1:0] lanes_q [LANES];

  // Each lane decodes its own index, so an out-of-range select simply hits nothing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < LANES; k++) begin
        lanes_q[k] <= '0;
      end
    end else if (wr_en_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_lane_i == SEL_W'(k)) begin
          lanes_q[k] <= wr_data_i;
        end
      end
    end
  end

  always_comb begin
    ir_o = '0;
    for (int k = 0; k < LANES; k++) begin
      ir_o[k*LANE_WIDTH +: LANE_WIDTH] = lanes_q[k];
    end
  end

endmodule

// File: rtl/instruction_fetch_register.sv
// rtl/instruction_fetch_register.sv - multi-lane instruction register with fetch sequencer
// Purpose: holds a LANES x LANE_WIDTH instruction loaded by direct lane writes
//          or by an automatic fetch of LANES consecutive bus words.
// Ports:   Clock      rising-edge clock
//          Reset      synchronous active-high reset, aborts a fetch
//          I          memory bus word
//          LaneSel    lane index for direct writes
//          Write      direct write enable (IDLE only)
//          Start      request an automatic fetch (IDLE only)
//          DataValid  memory word on I is valid this cycle
//          ByteReq    sequencer requesting a word (FETCH)
//          ByteIndex  lane being filled, 0 outside FETCH
//          Busy       high in FETCH and DONE
//          Done       one-cycle completion pulse
//          IROut      instruction register contents
module instruction_fetch_register
  import cpu_pkg::*;
#(
  parameter  int LANE_WIDTH = CPU_LANE_WIDTH,
  parameter  int LANES      = CPU_LANES,
  parameter  int FILL_ORDER = 0,
  localparam int SEL_W      = sel_width(LANES)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [LANE_WIDTH-1:0]       I,
  input  logic [SEL_W-1:0]            LaneSel,
  input  logic                        Write,
  input  logic                        Start,
  input  logic                        DataValid,
  output logic                        ByteReq,
  output logic [SEL_W-1:0]            ByteIndex,
  output logic                        Busy,
  output logic                        Done,
  output logic [LANES*LANE_WIDTH-1:0] IROut
);

  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(LANES - 1);

  fetch_state_t     state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] fill_lane;
  logic             wr_en;
  logic [SEL_W-1:0] wr_lane;

  // MSB-first fetches walk the lanes downwards from the top lane.
  assign fill_lane = (FILL_ORDER != 0) ? (LAST_CNT - cnt_q) : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (DataValid) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Direct writes own the port in IDLE, the sequencer owns it in FETCH,
  // and nothing may write while DONE presents the finished instruction.
  always_comb begin
    wr_en   = 1'b0;
    wr_lane = LaneSel;
    case (state_q)
      IDLE:  wr_en = Write;
      FETCH: begin
        wr_en   = DataValid;
        wr_lane = fill_lane;
      end
      default: wr_en = 1'b0;
    endcase
  end

  ir_lane_bank #(
    .LANE_WIDTH (LANE_WIDTH),
    .LANES      (LANES),
    .SEL_W      (SEL_W)
  ) u_lane_bank (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .wr_en_i   (wr_en),
    .wr_lane_i (wr_lane),
    .wr_data_i (I),
    .ir_o      (IROut)
  );

  assign ByteReq   = (state_q == FETCH);
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign ByteIndex = (state_q == FETCH) ? fill_lane : '0;

endmodule

// File: tb/tb_instruction_fetch_register.sv
// tb/tb_instruction_fetch_register.sv - self-checking bench for instruction_fetch_register
module tb_instruction_fetch_register;

  logic       clk;
  logic       rst  [3];
  logic       wr   [3];
  logic       st   [3];
  logic       dv   [3];
  logic [7:0] din  [3];
  logic [1:0] sel  [3];
  logic       req  [3];
  logic       busy [3];
  logic       done [3];
  logic [0:0] idx0;
  logic [1:0] idx1, idx2;
  logic [15:0] ir0;
  logic [31:0] ir1;
  logic [23:0] ir2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // inst0: LANES=2 LSB-first, inst1: LANES=4 MSB-first, inst2: LANES=3 LSB-first
  int lanes_of [3] = '{2, 4, 3};
  int fo_of    [3] = '{0, 1, 0};
  int selw_of  [3] = '{1, 2, 2};

  initial clk = 0;
  always #5 clk = ~clk;

  instruction_fetch_register #(.LANE_WIDTH(8), .LANES(2), .FILL_ORDER(0)) dut0 (
    .Clock(clk), .Reset(rst[0]), .I(din[0]), .LaneSel(sel[0][0:0]), .Write(wr[0]),
    .Start(st[0]), .DataValid(dv[0]), .ByteReq(req[0]), .ByteIndex(idx0),
    .Busy(busy[0]), .Done(done[0]), .IROut(ir0));

  instruction_fetch_register #(.LANE_WIDTH(8), .LANES(4), .FILL_ORDER(1)) dut1 (
    .Clock(clk), .Reset(rst[1]), .I(din[1]), .LaneSel(sel[1]), .Write(wr[1]),
    .Start(st[1]), .DataValid(dv[1]), .ByteReq(req[1]), .ByteIndex(idx1),
    .Busy(busy[1]), .Done(done[1]), .IROut(ir1));

  instruction_fetch_register #(.LANE_WIDTH(8), .LANES(3), .FILL_ORDER(0)) dut2 (
    .Clock(clk), .Reset(rst[2]), .I(din[2]), .LaneSel(sel[2]), .Write(wr[2]),
    .Start(st[2]), .DataValid(dv[2]), .ByteReq(req[2]), .ByteIndex(idx2),
    .Busy(busy[2]), .Done(done[2]), .IROut(ir2));

  // Behavioural model: phase 0 = waiting, 1 = collecting words, 2 = complete.
  logic [31:0] m_ir [3];
  int          m_ph [3];
  int          m_got[3];

  function automatic int model_lane(input int i, input int got);
    return (fo_of[i] != 0) ? (lanes_of[i] - 1 - got) : got;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_ir[i]  <= '0;
        m_ph[i]  <= 0;
        m_got[i] <= 0;
      end else if (m_ph[i] == 0) begin
        if (wr[i] && ((int'(sel[i]) % (1 << selw_of[i])) < lanes_of[i]))
          m_ir[i][(int'(sel[i]) % (1 << selw_of[i])) * 8 +: 8] <= din[i];
        if (st[i]) begin
          m_ph[i]  <= 1;
          m_got[i] <= 0;
        end
      end else if (m_ph[i] == 1) begin
        if (dv[i]) begin
          m_ir[i][model_lane(i, m_got[i]) * 8 +: 8] <= din[i];
          if (m_got[i] + 1 == lanes_of[i]) m_ph[i] <= 2;
          else m_got[i] <= m_got[i] + 1;
        end
      end else begin
        m_ph[i] <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ir_of(input int i);
    case (i)
      0:       return {16'h0, ir0};
      1:       return ir1;
      default: return {8'h0, ir2};
    endcase
  endfunction

  function automatic logic [31:0] idx_of(input int i);
    case (i)
      0:       return {31'h0, idx0};
      1:       return {30'h0, idx1};
      default: return {30'h0, idx2};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ir%0d", i),   ir_of(i), m_ir[i]);
        check($sformatf("req%0d", i),  {31'h0, req[i]},  {31'h0, m_ph[i] == 1});
        check($sformatf("busy%0d", i), {31'h0, busy[i]}, {31'h0, m_ph[i] != 0});
        check($sformatf("done%0d", i), {31'h0, done[i]}, {31'h0, m_ph[i] == 2});
        check($sformatf("idx%0d", i),  idx_of(i),
              (m_ph[i] == 1) ? 32'(model_lane(i, m_got[i])) : 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words1 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] words2 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] words3 [3] = '{8'h10, 8'h20, 8'h30};

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1; wr[i] = 0; st[i] = 0; dv[i] = 0; din[i] = 0; sel[i] = 0;
      m_ir[i] = '0; m_ph[i] = 0; m_got[i] = 0;
    end
    cyc();
    chk_en = 1;
    check("rst_ir0", {16'h0, ir0}, 32'h0);
    check("rst_ir1", ir1, 32'h0);
    check("rst_busy1", {31'h0, busy[1]}, 32'h0);
    cyc();
    for (int i = 0; i < 3; i++) rst[i] = 0;

    // direct lane writes
    wr[0] = 1; sel[0] = 0; din[0] = 8'h3C; cyc();
    sel[0] = 1; din[0] = 8'hA5; cyc();
    check("wr_ir0", {16'h0, ir0}, 32'h0000A53C);
    wr[0] = 0;
    repeat (3) cyc();
    check("hold_ir0", {16'h0, ir0}, 32'h0000A53C);

    // LSB-first fetch, Done three edges after Start is taken
    st[0] = 1; cyc(); st[0] = 0;
    check("f0_idx_a", {31'h0, idx0}, 32'd0);
    dv[0] = 1; din[0] = 8'h11; cyc();
    check("f0_idx_b", {31'h0, idx0}, 32'd1);
    check("f0_nodone", {31'h0, done[0]}, 32'd0);
    din[0] = 8'h22; cyc();
    check("f0_done", {31'h0, done[0]}, 32'd1);
    check("f0_ir", {16'h0, ir0}, 32'h00002211);
    dv[0] = 0; cyc();
    check("f0_done_end", {31'h0, done[0]}, 32'd0);

    // MSB-first fetch on four lanes
    st[1] = 1; cyc(); st[1] = 0; dv[1] = 1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("f1_idx%0d", k), {30'h0, idx1}, 32'(3 - k));
      din[1] = words1[k]; cyc();
    end
    check("f1_done", {31'h0, done[1]}, 32'd1);
    check("f1_ir", ir1, 32'hDEADBEEF);
    dv[1] = 0; cyc();

    // stall while Write/Start are thrown at the busy sequencer
    st[1] = 1; cyc(); st[1] = 0;
    for (int k = 0; k < 5; k++) begin
      wr[1] = 1; sel[1] = 2'(k); din[1] = 8'h55; st[1] = k[0];
      cyc();
      check("stall_busy", {31'h0, busy[1]}, 32'd1);
      check("stall_req", {31'h0, req[1]}, 32'd1);
      check("stall_ir", ir1, 32'hDEADBEEF);
    end
    wr[1] = 0; st[1] = 0; dv[1] = 1;
    for (int k = 0; k < 4; k++) begin
      din[1] = words2[k]; cyc();
    end
    check("stall_done", {31'h0, done[1]}, 32'd1);
    check("stall_ir_end", ir1, 32'h01020304);
    dv[1] = 0; cyc();

    // reset in the middle of a fetch
    st[0] = 1; cyc(); st[0] = 0;
    dv[0] = 1; din[0] = 8'h77; cyc();
    check("abort_pre", {16'h0, ir0}, 32'h00002277);
    rst[0] = 1; dv[0] = 0; cyc();
    check("abort_ir", {16'h0, ir0}, 32'h0);
    check("abort_busy", {31'h0, busy[0]}, 32'd0);
    check("abort_req", {31'h0, req[0]}, 32'd0);
    rst[0] = 0;
    repeat (4) begin
      cyc();
      check("abort_nodone", {31'h0, done[0]}, 32'd0);
    end

    // one-bit select folds index 3 onto lane 1
    wr[0] = 1; sel[0] = 2'd3; din[0] = 8'h9C; cyc();
    wr[0] = 0;
    check("sel_fold", {16'h0, ir0}, 32'h00009C00);

    // out-of-range lane on three lanes, then Write+Start together
    wr[2] = 1; sel[2] = 2'd1; din[2] = 8'h5A; cyc();
    sel[2] = 2'd3; din[2] = 8'hFF; cyc();
    check("oor_ir2", {8'h0, ir2}, 32'h00005A00);
    sel[2] = 2'd0; din[2] = 8'hC3; st[2] = 1; cyc();
    wr[2] = 0; st[2] = 0;
    check("ws_ir2", {8'h0, ir2}, 32'h00005AC3);
    check("ws_busy2", {31'h0, busy[2]}, 32'd1);
    check("ws_req2", {31'h0, req[2]}, 32'd1);
    dv[2] = 1;
    for (int k = 0; k < 3; k++) begin
      din[2] = words3[k]; cyc();
    end
    check("f2_done", {31'h0, done[2]}, 32'd1);
    check("f2_ir", {8'h0, ir2}, 32'h00302010);
    dv[2] = 0;
    repeat (2) cyc();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
